ads_sample_averager: RTL and testbench

- Sits directly downstream of the ADS1672-EVM controller.
- Issues one `measure` pulse per conversion and captures each 24-bit two's-complement sample.
- Accumulates 2^LOG2_AVG samples and presents the mean to the host/FIFO on a valid/ready interface.
- Flags missing samples (timeout) and unsolicited samples (stray).

---
 rtl/ads_pkg.sv | 16 +
 rtl/ads_avg_shift.sv | 50 +++++
 rtl/ads_sample_averager.sv | 142 ++++++++++++++
 tb/tb_ads_sample_averager.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ads_pkg.sv
// Shared types for the ADS1672 sample averager: data width, FSM state
// encoding and the signed sample type.
package ads_pkg;

    localparam int ADS_DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_SAMPLE,
        OUTPUT
    } avg_state_e;

    typedef logic signed [ADS_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/ads_avg_shift.sv
// Combinational accumulator-to-average conversion.
// Default build: floor division by 2^LOG2_AVG (arithmetic shift).
// With ADS_AVG_ROUND_EN defined: round half toward +inf, saturating at the
// largest positive DATA_WIDTH value.
module ads_avg_shift
    import ads_pkg::*;
#(
    parameter int DATA_WIDTH = ADS_DATA_WIDTH,
    parameter int LOG2_AVG   = 4,
    parameter int ACC_W      = DATA_WIDTH + LOG2_AVG
) (
    input  logic signed [ACC_W-1:0]      acc,
    output logic signed [DATA_WIDTH-1:0] avg
);

    generate
        if (LOG2_AVG == 0) begin : g_pass
            // A single sample is its own average.
            assign avg = acc[DATA_WIDTH-1:0];
        end
`ifdef ADS_AVG_ROUND_EN
        else begin : g_round
            localparam int SUM_W = ACC_W + 1;
            localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(1) << (LOG2_AVG - 1);
            localparam logic signed [SUM_W-1:0] MAX_POS =
                {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

            logic signed [SUM_W-1:0] sum;
            logic signed [SUM_W-1:0] shifted;

            // One extra bit keeps the rounding add from wrapping a large
            // positive accumulator into the negative range.
            assign sum     = {acc[ACC_W-1], acc} + HALF;
            assign shifted = sum >>> LOG2_AVG;
            assign avg     = (shifted > MAX_POS) ? MAX_POS[DATA_WIDTH-1:0]
                                                 : shifted[DATA_WIDTH-1:0];
        end
`else
        else begin : g_floor
            logic unused_frac;

            // ACC_W = DATA_WIDTH + LOG2_AVG, so the floor shift is exactly
            // the upper DATA_WIDTH bits; the fraction bits are dropped.
            assign avg         = acc[LOG2_AVG +: DATA_WIDTH];
            assign unused_frac = ^acc[LOG2_AVG-1:0];
        end
`endif
    endgenerate

endmodule

// File: rtl/ads_sample_averager.sv
// ADS1672 sample averager: requests one conversion per measure pulse,
// accumulates 2^LOG2_AVG signed samples and offers the mean on a
// valid/ready port. Missing samples raise timeout_err, unsolicited samples
// raise stray_err. Optional rounding: define ADS_AVG_ROUND_EN.
module ads_sample_averager
    import ads_pkg::*;
#(
    parameter int DATA_WIDTH     = ADS_DATA_WIDTH,
    parameter int LOG2_AVG       = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic                         measure,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid,
    output logic signed [DATA_WIDTH-1:0] avg_out,
    output logic                         avg_valid,
    input  logic                         avg_ready,
    output logic                         busy,
    output logic                         timeout_err,
    output logic                         stray_err
);

    localparam int ACC_W = DATA_WIDTH + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    avg_state_e                    state;
    avg_state_e                    next_state;
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       acc_sum;
    logic signed [DATA_WIDTH-1:0]  avg_next;
    logic [CNT_W-1:0]              count;
    logic [TMO_W-1:0]              tmo_cnt;
    logic                          enable_q;
    logic                          enable_rise;
    logic                          in_wait;
    logic                          take_sample;
    logic                          last_sample;
    logic                          tmo_hit;

    // Sign-extending cast: the accumulator is wide enough that N samples
    // can never overflow it.
    assign acc_sum     = acc + ACC_W'(sample_in);
    assign enable_rise = enable && !enable_q;
    assign in_wait     = (state == WAIT_SAMPLE) && enable;
    assign take_sample = in_wait && sample_valid;
    assign last_sample = (count == LAST_CNT);
    // A sample arriving on the terminal-count cycle wins over the timeout.
    assign tmo_hit     = in_wait && !sample_valid && (tmo_cnt == TMO_LAST);

    assign avg_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);

    ads_avg_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_AVG   (LOG2_AVG),
        .ACC_W      (ACC_W)
    ) u_shift (
        .acc (acc_sum),
        .avg (avg_next)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode; enable low aborts REQUEST/WAIT_SAMPLE, not OUTPUT.
    // NOTE: next_state gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (enable) next_state = REQUEST;
            REQUEST:     next_state = enable ? WAIT_SAMPLE : IDLE;
            WAIT_SAMPLE: begin
                if (!enable)          next_state = IDLE;
                else if (sample_valid) next_state = last_sample ? OUTPUT : REQUEST;
                else if (tmo_hit)     next_state = IDLE;
            end
            OUTPUT:      if (avg_ready) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Datapath: accumulator, sample/timeout counters, result register and
    // the measure pulse (registered copy of REQUEST).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            tmo_cnt  <= '0;
            avg_out  <= '0;
            measure  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            measure  <= (state == REQUEST) && enable;
            case (state)
                IDLE: begin
                    acc   <= '0;
                    count <= '0;
                end
                REQUEST: tmo_cnt <= '0;
                WAIT_SAMPLE: begin
                    if (take_sample) begin
                        acc <= acc_sum;
                        if (last_sample) avg_out <= avg_next;
                        else             count   <= count + CNT_W'(1);
                    end else if (in_wait) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags; an enable 0->1 edge clears them, a new event on
    // the same cycle still sets them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            stray_err   <= 1'b0;
        end else begin
            if (enable_rise) begin
                timeout_err <= 1'b0;
                stray_err   <= 1'b0;
            end
            if (tmo_hit)                                timeout_err <= 1'b1;
            if (sample_valid && (state != WAIT_SAMPLE)) stray_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ads_sample_averager.sv
// Directed bench for ads_sample_averager (LOG2_AVG=2, TIMEOUT_CYCLES=8).
// Expected averages depend on ADS_AVG_ROUND_EN.
module tb_ads_sample_averager;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        measure;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic [23:0] avg_out;
    logic        avg_valid;
    logic        avg_ready;
    logic        busy;
    logic        timeout_err;
    logic        stray_err;

    int checks   = 0;
    int failures = 0;
    int meas_cnt = 0;
    int meas_base;

`ifdef ADS_AVG_ROUND_EN
    localparam logic [23:0] EXP_NEG  = 24'hFFFFFF;
    localparam logic [23:0] EXP_1234 = 24'h000003;
`else
    localparam logic [23:0] EXP_NEG  = 24'hFFFFFE;
    localparam logic [23:0] EXP_1234 = 24'h000002;
`endif

    ads_sample_averager #(
        .DATA_WIDTH     (24),
        .LOG2_AVG       (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .measure      (measure),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .stray_err    (stray_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count measure pulses mid-cycle.
    always @(negedge clk) if (measure === 1'b1) meas_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_measure(input string tag);
        int n = 0;
        while (measure !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, measure, 1);
    endtask

    // Answer the current measure pulse one cycle later with a sample.
    task automatic feed_sample(input logic [23:0] v);
        wait_measure("measure_seen");
        tick();
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic run_burst(input string tag, input logic [23:0] s0, input logic [23:0] s1,
                             input logic [23:0] s2, input logic [23:0] s3,
                             input logic [23:0] exp);
        enable = 1'b1;
        feed_sample(s0);
        feed_sample(s1);
        feed_sample(s2);
        feed_sample(s3);
        check({tag, "_valid"}, avg_valid, 1);
        check({tag, "_avg"}, avg_out, exp);
        enable = 1'b0;
        tick();
        check({tag, "_done"}, avg_valid, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        avg_ready    = 1'b1;
        repeat (3) tick();
        check("rst_measure", measure, 0);
        check("rst_avg_valid", avg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_avg_out", avg_out, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_stray", stray_err, 0);
        rst_n = 1'b1;
        tick();

        // Basic burst 10,20,30,40 -> 25, then a new burst starts.
        meas_base = meas_cnt;
        enable = 1'b1;
        tick();
        check("lat_measure_1", measure, 0);
        check("lat_busy_1", busy, 1);
        tick();
        check("lat_measure_2", measure, 1);
        feed_sample(24'd10);
        feed_sample(24'd20);
        feed_sample(24'd30);
        feed_sample(24'd40);
        check("basic_valid", avg_valid, 1);
        check("basic_avg", avg_out, 24'd25);
        check("basic_pulses", meas_cnt - meas_base, 4);
        tick();
        check("basic_valid_drop", avg_valid, 0);
        check("basic_idle", busy, 0);
        tick();
        check("rerun_busy", busy, 1);
        check("rerun_measure_0", measure, 0);
        tick();
        check("rerun_measure_1", measure, 1);
        enable = 1'b0;
        tick();
        check("abort_idle", busy, 0);
        check("abort_no_timeout", timeout_err, 0);
        check("abort_no_stray", stray_err, 0);
        tick();

        // Signed and boundary averages.
        run_burst("neg", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, EXP_NEG);
        run_burst("mix", 24'd1, 24'd2, 24'd3, 24'd4, EXP_1234);
        run_burst("maxpos", 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        run_burst("minneg", 24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'h800000);
        run_burst("negexact", 24'hFFFFF6, 24'hFFFFEC, 24'hFFFFE2, 24'hFFFFD8, 24'hFFFFE7);

        // Timeout: no sample after measure.
        enable = 1'b1;
        wait_measure("tmo_measure");
        repeat (7) tick();
        check("tmo_not_yet", timeout_err, 0);
        check("tmo_still_busy", busy, 1);
        tick();
        check("tmo_flag", timeout_err, 1);
        check("tmo_idle", busy, 0);
        tick();
        check("tmo_rerun_m0", measure, 0);
        tick();
        check("tmo_rerun_m1", measure, 1);
        check("tmo_sticky", timeout_err, 1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check("tmo_clear", timeout_err, 0);
        enable = 1'b0;
        repeat (2) tick();

        // Backpressure in OUTPUT with enable dropped.
        avg_ready = 1'b0;
        enable    = 1'b1;
        feed_sample(24'd100);
        feed_sample(24'd200);
        feed_sample(24'd300);
        feed_sample(24'd400);
        check("bp_valid", avg_valid, 1);
        check("bp_avg", avg_out, 24'd250);
        enable    = 1'b0;
        meas_base = meas_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", avg_valid, 1);
            check("bp_hold_avg", avg_out, 24'd250);
        end
        avg_ready = 1'b1;
        tick();
        check("bp_accept_valid", avg_valid, 0);
        check("bp_accept_busy", busy, 0);
        repeat (4) tick();
        check("bp_no_measure", meas_cnt - meas_base, 0);
        check("bp_stay_idle", busy, 0);

        // Stray samples, then asynchronous reset mid-WAIT_SAMPLE.
        sample_in    = 24'd7;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("stray_idle", stray_err, 1);
        check("stray_idle_busy", busy, 0);
        enable = 1'b1;
        tick();
        check("stray_clear", stray_err, 0);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("stray_request", stray_err, 1);
        check("wait_measure_hi", measure, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_measure", measure, 0);
        check("arst_busy", busy, 0);
        check("arst_avg_valid", avg_valid, 0);
        check("arst_avg_out", avg_out, 0);
        check("arst_stray", stray_err, 0);
        check("arst_timeout", timeout_err, 0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
